// File: rtl/m040_bus_master.sv
// 68040-protocol bus initiator: issues single and 4-beat line transfers, with TBI fallback and TEA abort.
// Optional per-beat TA/TEA timeout is compiled in when M040_BUS_TIMEOUT_EN is defined.
module m040_bus_master #(
`ifdef M040_BUS_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 64,
`endif
    parameter logic [2:0]  TM_DEFAULT     = 3'b101
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_rw,
    input  logic [1:0]  req_siz,
    output logic [1:0]  beat_idx,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic [31:0] A,
    output logic [1:0]  SIZ,
    output logic [1:0]  TT,
    output logic [2:0]  TM,
    output logic        nWR,
    output logic        nTS,
    output logic        nTIP,
    output logic [31:0] D_out,
    output logic        D_oe,
    input  logic [31:0] D_in,
    input  logic        nTA,
    input  logic        nTBI,
    input  logic        nTEA
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [27:0]   r_base;
    logic [1:0]    r_lw;
    logic          r_rw;
    logic          r_line;
    logic          r_fallback;
    logic [1:0]    r_beat;
    logic [31:0]   r_rd_data;
    logic          r_rd_valid;
    logic          r_done;
    logic          r_err;
    logic [31:0]   r_a;
    logic [1:0]    r_siz;
    logic [2:0]    r_tm;
    logic          r_nwr;
    logic          r_nts;
    logic          r_ntip;
    logic          r_d_oe;

    logic          w_accept;
    logic          w_ta;
    logic          w_tea;
    logic          w_timeout;
    logic          w_last;
    logic          w_go_fallback;
    logic [1:0]    w_next_beat;
    logic [1:0]    w_fb_lw;

    assign w_accept      = req_valid && req_ready;
    assign w_ta          = !nTA;
    assign w_tea         = !nTEA;
    assign w_next_beat   = r_beat + 2'd1;
    assign w_fb_lw       = r_lw + w_next_beat;
    assign w_last        = !r_line || (r_beat == 2'd3);
    // Burst inhibit only matters on the first beat of a genuine line transfer.
    assign w_go_fallback = r_line && !r_fallback && (r_beat == 2'd0) && !nTBI;

`ifdef M040_BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_WAIT || w_ta || w_tea) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_lw       <= '0;
            r_rw       <= 1'b1;
            r_line     <= 1'b0;
            r_fallback <= 1'b0;
            r_beat     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_a        <= '0;
            r_siz      <= '0;
            r_tm       <= '0;
            r_nwr      <= 1'b1;
            r_nts      <= 1'b1;
            r_ntip     <= 1'b1;
            r_d_oe     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_base     <= req_addr[31:4];
                        r_lw       <= req_addr[3:2];
                        r_rw       <= req_rw;
                        r_line     <= (req_siz == 2'b11);
                        r_fallback <= 1'b0;
                        r_beat     <= '0;
                        r_a        <= req_addr;
                        r_siz      <= req_siz;
                        r_nwr      <= req_rw;
                        r_tm       <= TM_DEFAULT;
                        r_nts      <= 1'b0;
                        r_ntip     <= 1'b0;
                        r_d_oe     <= !req_rw;
                        r_state    <= ST_START;
                    end else begin
                        // nTIP is held through the done cycle so a back-to-back request keeps it low.
                        r_ntip     <= 1'b1;
                    end
                end
                ST_START: begin
                    r_nts   <= 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_tea) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_ntip  <= 1'b1;
                        r_d_oe  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_ta) begin
                        if (r_rw) begin
                            r_rd_data  <= D_in;
                            r_rd_valid <= 1'b1;
                        end
                        r_beat <= w_next_beat;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_d_oe  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (w_go_fallback || r_fallback) begin
                            r_fallback <= 1'b1;
                            r_a        <= {r_base, w_fb_lw, 2'b00};
                            r_siz      <= 2'b00;
                            r_nts      <= 1'b0;
                            r_state    <= ST_START;
                        end
                    end else if (w_timeout) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_ntip  <= 1'b1;
                        r_d_oe  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign beat_idx  = r_beat;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign A         = r_a;
    assign SIZ       = r_siz;
    assign TT        = 2'b00;
    assign TM        = r_tm;
    assign nWR       = r_nwr;
    assign nTS       = r_nts;
    assign nTIP      = r_ntip;
    assign D_oe      = r_d_oe;
    // Write data is indexed by beat_idx upstream, so it is passed straight through while driving.
    assign D_out     = r_d_oe ? wr_data : 32'd0;

endmodule

// File: tb/tb_m040_bus_master.sv
// Randomized bench for m040_bus_master: a cycle-level expectation model driven alongside a scripted responder.
// Builds with or without M040_BUS_TIMEOUT_EN (timeout set to 8 cycles when enabled).
module tb_m040_bus_master;

`ifdef M040_BUS_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic        clk = 1'b0;
    logic        nRESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_siz;
    logic [1:0]  beat_idx;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic [31:0] A;
    logic [1:0]  SIZ;
    logic [1:0]  TT;
    logic [2:0]  TM;
    logic        nWR;
    logic        nTS;
    logic        nTIP;
    logic [31:0] D_out;
    logic        D_oe;
    logic [31:0] D_in;
    logic        nTA;
    logic        nTBI;
    logic        nTEA;

    always #5 clk = ~clk;

    m040_bus_master #(
`ifdef M040_BUS_TIMEOUT_EN
        .TIMEOUT_CYCLES(TMO),
`endif
        .TM_DEFAULT(3'b101)
    ) dut (
        .clk(clk), .nRESET(nRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_siz(req_siz), .beat_idx(beat_idx),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .A(A), .SIZ(SIZ), .TT(TT), .TM(TM),
        .nWR(nWR), .nTS(nTS), .nTIP(nTIP), .D_out(D_out), .D_oe(D_oe),
        .D_in(D_in), .nTA(nTA), .nTBI(nTBI), .nTEA(nTEA)
    );

    logic [31:0] wdata_arr [4];
    always_comb wr_data = wdata_arr[beat_idx];

    // Expected bus state for the current cycle, updated by the responder task.
    bit          chk_en;
    bit          m_active, m_rw, m_ts, m_rdv, m_done, m_err;
    logic        m_tip;
    logic [31:0] m_addr, m_rdata;
    logic [1:0]  m_siz, m_beat;

    int          pass_cnt = 0;
    int          check_cnt = 0;
    int          done_cnt;
    logic [31:0] ts_log [$];
    logic [31:0] rd_log [$];
    int          ws_q [4];
    logic [31:0] din_q [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                chk("nTS", {31'd0, nTS}, {31'd0, !m_ts});
                chk("nTIP", {31'd0, nTIP}, {31'd0, m_tip});
                chk("D_oe", {31'd0, D_oe}, {31'd0, m_active && !m_rw});
                chk("req_ready", {31'd0, req_ready}, {31'd0, !m_active});
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
                chk("done", {31'd0, done}, {31'd0, m_done});
                chk("err", {31'd0, err}, {31'd0, m_err});
                chk("TT", {30'd0, TT}, 32'd0);
                if (m_rdv) chk("rd_data", rd_data, m_rdata);
                if (m_active) begin
                    chk("A", A, m_addr);
                    chk("SIZ", {30'd0, SIZ}, {30'd0, m_siz});
                    chk("nWR", {31'd0, nWR}, {31'd0, m_rw});
                    chk("TM", {29'd0, TM}, 32'd5);
                    chk("beat_idx", {30'd0, beat_idx}, {30'd0, m_beat});
                    if (!m_rw) chk("D_out", D_out, wdata_arr[m_beat]);
                end
                if (!nTS) ts_log.push_back(A);
                if (rd_valid) rd_log.push_back(rd_data);
                if (done) done_cnt++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        m_rdv = 0; m_done = 0; m_err = 0; m_ts = 0;
    endtask

    task automatic clear_logs();
        ts_log.delete(); rd_log.delete(); done_cnt = 0;
    endtask

    task automatic do_reset();
        chk_en = 0;
        #1 nRESET = 1'b0;
        #1;
        chk("rst_nTS", {31'd0, nTS}, 32'd1);
        chk("rst_nTIP", {31'd0, nTIP}, 32'd1);
        chk("rst_nWR", {31'd0, nWR}, 32'd1);
        chk("rst_D_oe", {31'd0, D_oe}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        m_active = 0; m_tip = 1'b1;
        step();
        step();
        nRESET = 1'b1;
        step();
        chk_en = 1;
    endtask

    task automatic run_txn(input logic [31:0] addr, input bit rw, input logic [1:0] siz,
                           input bit tbi, input int tea_beat, input bit tea_ta,
                           input bit b2b, input int rst_beat);
        bit line, fb;
        int nb;
        line = (siz == 2'b11);
        fb   = 0;
        nb   = line ? 4 : 1;
        req_addr = addr; req_rw = rw; req_siz = siz; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        m_active = 1; m_rw = rw; m_beat = 2'd0; m_tip = 1'b0; m_ts = 1;
        m_addr = addr; m_siz = siz;
        for (int b = 0; b < nb; b++) begin
            if (b == 0 || fb) step();
`ifdef M040_BUS_TIMEOUT_EN
            if (ws_q[b] >= TMO) begin
                repeat (TMO) step();
                m_active = 0; m_tip = 1'b1; m_done = 1; m_err = 1;
                step();
                return;
            end
`endif
            repeat (ws_q[b]) step();
            if (b == rst_beat) begin
                do_reset();
                return;
            end
            D_in = din_q[b];
            if (b == tea_beat) begin
                nTEA = 1'b0;
                nTA  = tea_ta ? 1'b0 : 1'b1;
            end else begin
                nTA = 1'b0;
            end
            nTBI = (line && b == 0) ? !tbi : 1'($urandom_range(0, 1));
            step();
            nTA = 1'b1; nTEA = 1'b1; nTBI = 1'b1; D_in = $urandom;
            if (b == tea_beat) begin
                m_active = 0; m_tip = 1'b1; m_done = 1; m_err = 1;
                step();
                return;
            end
            if (rw) begin
                m_rdv = 1; m_rdata = din_q[b];
            end
            m_beat = m_beat + 2'd1;
            if (b == nb - 1) begin
                m_active = 0; m_done = 1;
            end else if (line && (fb || (b == 0 && tbi))) begin
                fb = 1; m_ts = 1; m_siz = 2'b00;
                m_addr = {addr[31:4], 2'(addr[3:2] + m_beat), 2'b00};
            end
        end
        if (!b2b) begin
            step();
            m_tip = 1'b1;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp4 [4];
        logic [31:0] v;
        int          exp_done;
        chk_en = 0; m_active = 0; m_rw = 0; m_ts = 0; m_rdv = 0; m_done = 0; m_err = 0;
        m_tip = 1'b1; m_addr = '0; m_rdata = '0; m_siz = '0; m_beat = '0;
        nRESET = 1'b0; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0; req_siz = '0;
        D_in = '0; nTA = 1'b1; nTBI = 1'b1; nTEA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata_arr[i] = '0; ws_q[i] = 0; din_q[i] = '0;
        end
        clear_logs();
        repeat (2) @(negedge clk);
        #2;
        chk("reset_nTS", {31'd0, nTS}, 32'd1);
        chk("reset_nTIP", {31'd0, nTIP}, 32'd1);
        chk("reset_D_oe", {31'd0, D_oe}, 32'd0);
        chk("reset_A", A, 32'd0);
        chk("reset_TM", {29'd0, TM}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_beat_idx", {30'd0, beat_idx}, 32'd0);
        nRESET = 1'b1;
        step();
        chk_en = 1;
        step();

        // Line read with two wait states before the first TA.
        clear_logs();
        exp4[0] = 32'h11111111; exp4[1] = 32'h22222222; exp4[2] = 32'h33333333; exp4[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin din_q[i] = exp4[i]; ws_q[i] = 0; end
        ws_q[0] = 2;
        run_txn(32'h35555554, 1'b1, 2'b11, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("line_ts_count", ts_log.size(), 32'd1);
        if (ts_log.size() > 0) chk("line_ts_addr", ts_log[0], 32'h35555554);
        chk("line_rd_count", rd_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            v = (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF;
            chk("line_rd_data", v, exp4[i]);
        end
        chk("line_done_count", done_cnt, 32'd1);

        // Single long write.
        clear_logs();
        wdata_arr[0] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) ws_q[i] = 0;
        run_txn(32'h00001000, 1'b0, 2'b00, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("wr_done_count", done_cnt, 32'd1);
        chk("wr_rd_count", rd_log.size(), 32'd0);

        // Burst inhibited line read falls back to three long transfers.
        clear_logs();
        for (int i = 0; i < 4; i++) din_q[i] = $urandom;
        run_txn(32'h00002008, 1'b1, 2'b11, 1'b1, -1, 1'b0, 1'b0, -1);
        exp4[0] = 32'h2008; exp4[1] = 32'h200C; exp4[2] = 32'h2000; exp4[3] = 32'h2004;
        chk("tbi_ts_count", ts_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            v = (i < ts_log.size()) ? ts_log[i] : 32'hFFFF_FFFF;
            chk("tbi_ts_addr", v, exp4[i]);
        end
        chk("tbi_rd_count", rd_log.size(), 32'd4);

        // TEA together with TA on beat 1.
        clear_logs();
        run_txn(32'h00003000, 1'b1, 2'b11, 1'b0, 1, 1'b1, 1'b0, -1);
        chk("tea_rd_count", rd_log.size(), 32'd1);
        chk("tea_done_count", done_cnt, 32'd1);

        // No responder at all.
        clear_logs();
        ws_q[0] = 100;
        run_txn(32'h00004000, 1'b1, 2'b00, 1'b0, -1, 1'b0, 1'b0, 0);
`ifdef M040_BUS_TIMEOUT_EN
        exp_done = 1;
`else
        exp_done = 0;
`endif
        chk("noresp_done_count", done_cnt, exp_done);
        ws_q[0] = 0;

        // Reset during beat 2 of a line write, then a normal request.
        clear_logs();
        for (int i = 0; i < 4; i++) wdata_arr[i] = $urandom;
        ws_q[2] = 1;
        run_txn(32'h00005000, 1'b0, 2'b11, 1'b0, -1, 1'b0, 1'b0, 2);
        chk("rst_mid_done_count", done_cnt, 32'd0);
        ws_q[2] = 0;
        din_q[0] = 32'hCAFEF00D;
        run_txn(32'h00006004, 1'b1, 2'b10, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("after_rst_done_count", done_cnt, 32'd1);

        // Randomized mix of reads, writes, lines, fallbacks, errors and back-to-back requests.
        for (int n = 0; n < 40; n++) begin
            bit          rw, line, tbi, tea_ta, b2b;
            logic [1:0]  siz;
            int          tea_beat, nb;
            rw     = 1'($urandom_range(0, 1));
            line   = 1'($urandom_range(0, 1));
            siz    = line ? 2'b11 : 2'($urandom_range(0, 2));
            nb     = line ? 4 : 1;
            tbi    = line && ($urandom_range(0, 2) == 0);
            tea_beat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1;
            tea_ta = 1'($urandom_range(0, 1));
            b2b    = (tea_beat < 0) && ($urandom_range(0, 2) == 0) && (n < 39);
            for (int i = 0; i < 4; i++) begin
                ws_q[i] = $urandom_range(0, 3);
                din_q[i] = $urandom;
                wdata_arr[i] = $urandom;
            end
            run_txn({$urandom, 2'b00}, rw, siz, tbi, tea_beat, tea_ta, b2b, -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
